// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared single-port memory bus between instruction fetch and the load/store path.
// Each access runs over a req/ack bus; loads are extended and stores are lane-replicated here.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] NOP_INS        = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if2arb_req_i,
    input  logic [31:0] if2arb_addr_i,
    output logic        arb2if_ack_o,
    output logic [31:0] arb2if_ins_o,
    input  logic        exmem2arb_req_i,
    input  logic        exmem2arb_we_i,
    input  logic [31:0] exmem2arb_addr_i,
    input  logic [31:0] exmem2arb_wdata_i,
    input  logic [2:0]  exmem2arb_funct3_i,
    output logic        arb2exmem_ack_o,
    output logic [31:0] arb2exmem_rdata_o,
    output logic        arb2bus_req_o,
    output logic        arb2bus_we_o,
    output logic [31:0] arb2bus_addr_o,
    output logic [31:0] arb2bus_wdata_o,
    output logic [3:0]  arb2bus_be_o,
    input  logic        bus2arb_ack_i,
    input  logic [31:0] bus2arb_rdata_i,
    output logic        arb2cu_stall_o,
    output logic        arb2cu_err_o
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StIfBusy, StMemBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic             last_grant_q;  // 1 = data path was granted last
    logic             sel_data_q;
    logic [CntW-1:0]  cnt_q;
    logic [2:0]       funct3_q;
    logic [1:0]       addr_lo_q;
    logic [31:0]      data_q;
    logic             err_q;
    logic             bus_req_q, bus_we_q;
    logic [31:0]      bus_addr_q, bus_wdata_q;
    logic [3:0]       bus_be_q;

    logic        data_wins, misaligned, timeout, is_half, is_word;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [1:0]  d_lo;
    logic        unused_if_lo;

    assign unused_if_lo = ^if2arb_addr_i[1:0];
    assign d_lo = exmem2arb_addr_i[1:0];

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] d);
        logic [31:0] sh;
        logic [15:0] h;
        sh = d >> {a, 3'b000};
        h  = a[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'b0, sh[7:0]};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            default: return d;
        endcase
    endfunction

    // Load size decode treats bit 2 as the unsigned flag; stores only know SB/SH/SW.
    always_comb begin
        if (exmem2arb_we_i) begin
            is_half = (exmem2arb_funct3_i == 3'b001);
            is_word = (exmem2arb_funct3_i != 3'b000) && !is_half;
        end else begin
            is_half = (exmem2arb_funct3_i[1:0] == 2'b01);
            is_word = (exmem2arb_funct3_i[1:0] != 2'b00) && !is_half;
        end
        misaligned = (is_half && d_lo[0]) || (is_word && (d_lo != 2'b00));
        if (!exmem2arb_we_i) begin
            st_wdata = 32'b0;
            st_be    = 4'b1111;
        end else if (is_word) begin
            st_wdata = exmem2arb_wdata_i;
            st_be    = 4'b1111;
        end else if (is_half) begin
            st_wdata = {2{exmem2arb_wdata_i[15:0]}};
            st_be    = 4'b0011 << d_lo;
        end else begin
            st_wdata = {4{exmem2arb_wdata_i[7:0]}};
            st_be    = 4'b0001 << d_lo;
        end
    end

    assign data_wins = exmem2arb_req_i && (!if2arb_req_i || !last_grant_q);
    assign timeout   = !bus2arb_ack_i && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (data_wins)          state_d = misaligned ? StDone : StMemBusy;
                else if (if2arb_req_i)  state_d = StIfBusy;
            end
            StIfBusy, StMemBusy: begin
                if (bus2arb_ack_i || timeout) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b0;
            sel_data_q   <= 1'b0;
            cnt_q        <= '0;
            funct3_q     <= 3'b0;
            addr_lo_q    <= 2'b0;
            data_q       <= 32'b0;
            err_q        <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'b0;
            bus_wdata_q  <= 32'b0;
            bus_be_q     <= 4'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (data_wins) begin
                        sel_data_q   <= 1'b1;
                        last_grant_q <= 1'b1;
                        funct3_q     <= exmem2arb_funct3_i;
                        addr_lo_q    <= d_lo;
                        bus_we_q     <= exmem2arb_we_i;
                        bus_addr_q   <= {exmem2arb_addr_i[31:2], 2'b00};
                        bus_wdata_q  <= st_wdata;
                        bus_be_q     <= st_be;
                        bus_req_q    <= !misaligned;
                        err_q        <= misaligned;
                        data_q       <= 32'b0;
                    end else if (if2arb_req_i) begin
                        sel_data_q   <= 1'b0;
                        last_grant_q <= 1'b0;
                        bus_we_q     <= 1'b0;
                        bus_addr_q   <= {if2arb_addr_i[31:2], 2'b00};
                        bus_wdata_q  <= 32'b0;
                        bus_be_q     <= 4'b1111;
                        bus_req_q    <= 1'b1;
                        err_q        <= 1'b0;
                    end
                end
                StIfBusy, StMemBusy: begin
                    if (bus2arb_ack_i) begin
                        bus_req_q <= 1'b0;
                        cnt_q     <= '0;
                        if (!sel_data_q)    data_q <= bus2arb_rdata_i;
                        else if (bus_we_q)  data_q <= 32'b0;
                        else                data_q <= fmt_load(funct3_q, addr_lo_q, bus2arb_rdata_i);
                    end else if (timeout) begin
                        bus_req_q <= 1'b0;
                        cnt_q     <= '0;
                        err_q     <= 1'b1;
                        data_q    <= sel_data_q ? 32'b0 : NOP_INS;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    cnt_q <= '0;
                    err_q <= 1'b0;
                end
            endcase
        end
    end

    assign arb2if_ack_o      = (state_q == StDone) && !sel_data_q;
    assign arb2exmem_ack_o   = (state_q == StDone) && sel_data_q;
    assign arb2if_ins_o      = arb2if_ack_o ? data_q : 32'b0;
    assign arb2exmem_rdata_o = arb2exmem_ack_o ? data_q : 32'b0;
    assign arb2cu_err_o      = (state_q == StDone) && err_q;
    assign arb2bus_req_o     = bus_req_q;
    assign arb2bus_we_o      = bus_we_q;
    assign arb2bus_addr_o    = bus_addr_q;
    assign arb2bus_wdata_o   = bus_wdata_q;
    assign arb2bus_be_o      = bus_be_q;
    assign arb2cu_stall_o    = (if2arb_req_i && !arb2if_ack_o) ||
                               (exmem2arb_req_i && !arb2exmem_ack_o);
endmodule
